// File: rtl/seg_scan_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scan controller.
package seg_scan_pkg;

  localparam logic [7:0] SEG_BLANK  = 8'h00;
  localparam int         PWM_W      = 4;
  localparam int         MAX_DIGITS = 16;

  // All-inactive digit-select vector; callers slice it to their digit count.
  function automatic logic [MAX_DIGITS-1:0] com_inactive(input logic active_low);
    return active_low ? {MAX_DIGITS{1'b1}} : {MAX_DIGITS{1'b0}};
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot/digit/frame sequencing for the scan controller: slot counter with a
// per-slot length latch, digit index and free-wrapping frame counter.
module seg_scan_timer
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int DIV_WIDTH   = 16,
  parameter int BLINK_SHIFT = 5,
  localparam int DIG_W      = $clog2(NUM_DIGITS),
  localparam int FRM_W      = BLINK_SHIFT + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] scan_div_i,
  output logic [DIV_WIDTH-1:0] slot_cnt_o,
  output logic                 slot_first_o,
  output logic [DIG_W-1:0]     digit_idx_o,
  output logic [FRM_W-1:0]     frame_cnt_o
);

  logic [DIV_WIDTH-1:0] slot_cnt_q, slot_cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d, div_eff;
  logic [DIG_W-1:0]     digit_q, digit_d;
  logic [FRM_W-1:0]     frame_q, frame_d;
  logic                 slot_first, slot_last;

  always_comb begin
    slot_first = (slot_cnt_q == '0);
    // The first cycle of a slot already obeys the freshly sampled length.
    div_eff    = slot_first ? scan_div_i : div_q;
    slot_last  = (slot_cnt_q == div_eff);
    div_d      = div_eff;
    slot_cnt_d = slot_last ? '0 : slot_cnt_q + DIV_WIDTH'(1);
    digit_d    = digit_q;
    frame_d    = frame_q;
    if (slot_last) begin
      if (digit_q == DIG_W'(NUM_DIGITS - 1)) begin
        digit_d = '0;
        frame_d = frame_q + FRM_W'(1);
      end else begin
        digit_d = digit_q + DIG_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt_q <= '0;
      div_q      <= '0;
      digit_q    <= '0;
      frame_q    <= '0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      div_q      <= div_d;
      digit_q    <= digit_d;
      frame_q    <= frame_d;
    end
  end

  assign slot_cnt_o   = slot_cnt_q;
  assign slot_first_o = slot_first;
  assign digit_idx_o  = digit_q;
  assign frame_cnt_o  = frame_q;

endmodule

// File: rtl/seg_scan_controller.sv
// Multiplexed seven-segment scan controller: per-slot blanking, PWM brightness,
// per-digit enable and blink, with registered one-cycle-latency outputs.
module seg_scan_controller
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int DIV_WIDTH      = 16,
  parameter int BLANK_CYCLES   = 4,
  parameter int BLINK_SHIFT    = 5,
  parameter int COM_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS*8-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [DIV_WIDTH-1:0]    scan_div,
  input  logic [PWM_W-1:0]        brightness,
  output logic [NUM_DIGITS-1:0]   seg_COM,
  output logic [7:0]              seg_DATA,
  output logic                    frame_start
);

  localparam int DIG_W = $clog2(NUM_DIGITS);
  localparam int FRM_W = BLINK_SHIFT + 1;
  localparam logic [MAX_DIGITS-1:0] COM_OFF_ALL = com_inactive(COM_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] COM_OFF     = COM_OFF_ALL[NUM_DIGITS-1:0];

  logic [DIV_WIDTH-1:0]  slot_cnt;
  logic                  slot_first;
  logic [DIG_W-1:0]      digit_idx;
  logic [FRM_W-1:0]      frame_cnt;

  logic [7:0]            seg_arr [NUM_DIGITS];
  logic [PWM_W-1:0]      pwm_q, pwm_d;
  logic [7:0]            hold_q, hold_d;
  logic [NUM_DIGITS-1:0] com_q, com_d;
  logic [7:0]            data_q, data_d;
  logic                  fs_q, fs_d;
  logic [NUM_DIGITS-1:0] digit_onehot;
  logic [7:0]            pattern;
  logic                  past_blank, blink_off, lit;

  seg_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .DIV_WIDTH   (DIV_WIDTH),
    .BLINK_SHIFT (BLINK_SHIFT)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .scan_div_i   (scan_div),
    .slot_cnt_o   (slot_cnt),
    .slot_first_o (slot_first),
    .digit_idx_o  (digit_idx),
    .frame_cnt_o  (frame_cnt)
  );

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_seg
    assign seg_arr[gi] = seg_in[8*gi +: 8];
  end

  always_comb begin
    digit_onehot = NUM_DIGITS'(1) << digit_idx;
    past_blank   = 32'(slot_cnt) >= BLANK_CYCLES;
    blink_off    = blink_mask[digit_idx] & frame_cnt[BLINK_SHIFT];
    lit          = past_blank && (pwm_q <= brightness) && digit_en[digit_idx] && !blink_off;
    // Bypass the holding register on the sampling cycle so a zero blank still shows data.
    pattern      = slot_first ? seg_arr[digit_idx] : hold_q;
    hold_d       = pattern;
    pwm_d        = pwm_q + PWM_W'(1);
    com_d        = lit ? (COM_OFF ^ digit_onehot) : COM_OFF;
    data_d       = lit ? pattern : SEG_BLANK;
    fs_d         = slot_first && (digit_idx == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_q  <= '0;
      hold_q <= SEG_BLANK;
      com_q  <= COM_OFF;
      data_q <= SEG_BLANK;
      fs_q   <= 1'b0;
    end else begin
      pwm_q  <= pwm_d;
      hold_q <= hold_d;
      com_q  <= com_d;
      data_q <= data_d;
      fs_q   <= fs_d;
    end
  end

  assign seg_COM     = com_q;
  assign seg_DATA    = data_q;
  assign frame_start = fs_q;

endmodule

// File: doc/seg_scan_controller.md
SEG_SCAN_CONTROLLER -- requirements
Module: seg_scan_controller

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of multiplexed digits, legal range 2..16.
REQ-002 Parameter DIV_WIDTH, default 16: width of scan_div.
REQ-003 Parameter BLANK_CYCLES, default 4: anti-ghosting blank at the start of each slot, in clk cycles.
REQ-004 Parameter BLINK_SHIFT, default 5: blink half-period is 2^BLINK_SHIFT frames.
REQ-005 Parameter COM_ACTIVE_LOW, default 1: 1 means a digit is selected by a 0 on its seg_COM bit.
REQ-006 clk  input  1  clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 seg_in  input  NUM_DIGITS*8  segment patterns; digit d occupies bits [8d+7:8d]; active-high segments.
REQ-009 digit_en  input  NUM_DIGITS  per-digit enable; 0 keeps that digit dark.
REQ-010 blink_mask  input  NUM_DIGITS  per-digit blink enable.
REQ-011 scan_div  input  DIV_WIDTH  slot length minus one, in clk cycles.
REQ-012 brightness  input  4  PWM duty: on for (brightness+1)/16 of the post-blank slot time.
REQ-013 seg_COM  output  NUM_DIGITS  digit select, polarity per COM_ACTIVE_LOW, at most one bit active.
REQ-014 seg_DATA  output  8  segment data for the selected digit.
REQ-015 frame_start  output  1  one-cycle pulse marking the start of digit 0's slot.

Function
REQ-016 A slot counter counts 0..slot_len-1, where slot_len is latched as scan_div+1 when the counter is 0; changes to scan_div mid-slot take effect at the next slot.
REQ-017 The digit index advances by one at the end of each slot and wraps from NUM_DIGITS-1 to 0; the wrap increments a frame counter.
REQ-018 seg_in for the current digit is sampled into a holding register when the slot counter is 0; seg_DATA is stable for the whole slot.
REQ-019 A 4-bit PWM counter runs freely, incrementing every clk and wrapping 15->0.
REQ-020 The digit is lit when all of these hold: slot counter >= BLANK_CYCLES; PWM counter <= brightness; digit_en[d]=1; and NOT (blink_mask[d]=1 AND frame_counter[BLINK_SHIFT]=1).
REQ-021 When lit, only seg_COM bit d is active and seg_DATA holds the sampled pattern; when not lit, all seg_COM bits are inactive and seg_DATA=8'h00.
REQ-022 Outputs are registered: the values in cycle t+1 reflect the counter state in cycle t (one-cycle latency).
REQ-023 A disabled or blink-blanked digit still consumes its full slot, so frame timing is independent of digit_en and blink_mask.
REQ-024 If slot_len <= BLANK_CYCLES, the digit is never lit in that slot; counters continue to advance normally.
REQ-025 frame_start is asserted for exactly one cycle, aligned with the first output cycle of digit 0's slot.
REQ-026 The frame counter has BLINK_SHIFT+1 bits and wraps silently.

Reset
REQ-027 While reset is high: seg_COM is all-inactive (all 1 if COM_ACTIVE_LOW, else all 0), seg_DATA=8'h00, frame_start=0, and the slot, digit, PWM and frame counters are all 0.
REQ-028 Reset asserted mid-slot takes effect on the next clk edge with no partial-slot completion; scanning restarts at digit 0 with frame_start on the first post-reset slot.

Structure
REQ-029 Package seg_scan_pkg holds SEG_BLANK=8'h00, the PWM width constant 4, and a function that returns an inactive COM vector for a given polarity.
REQ-030 Sub-module seg_scan_timer holds the slot counter, slot_len latch, digit index and frame counter, and outputs slot_first, digit_idx and frame_cnt; the top level holds the PWM, lit logic and output registers.

Verification
REQ-031 NUM_DIGITS=8, scan_div=15, BLANK_CYCLES=4, brightness=15, all enabled, seg_in digit d=8'h10+d -> each digit is lit for 12 of 16 cycles in order 0..7, seg_COM=~(1<<d), frame_start pulses every 128 cycles.
REQ-032 Same setup with brightness=3 -> in each slot, COM is active only in cycles where PWM<=3 and slot counter>=4; no COM activity during blank cycles.
REQ-033 digit_en=8'b1111_1011 -> digit 2 is dark for its whole slot with seg_DATA=00, and the frame period is still 128 cycles.
REQ-034 BLINK_SHIFT=1, blink_mask=8'h01 -> digit 0 is lit in frames 0-1, dark in frames 2-3, and lit again in frames 4-5; other digits are unaffected.
REQ-035 scan_div changed from 15 to 3 mid-slot -> the current slot completes at 16 cycles, the next slot lasts 4 cycles, and no digit is lit (4 <= BLANK_CYCLES).
REQ-036 reset pulsed during digit 5's slot -> the next cycle shows all COM inactive and DATA=00; after release, digit 0 is first and frame_start is asserted.
